axi4_burst_selftest_master: RTL
===============================

# axi4_burst_selftest_master

Synthesizable AXI4 master that writes a configurable number of INCR bursts of a generated data pattern into a slave, reads them back and compares every beat in hardware. It replaces the simulation-only write-burst/read-burst/compare sequence in the IP bench. It also allows on-board self-test of the crypto IP's AXI4 slave window, with selectable data width, burst length, burst count and pattern mode. Sits beside the IP in the block design and connects straight to its S00_AXI port.

## Interface
- DATA_W, 32: AXI data width; 32, 64 or 128.
- ADDR_W, 32: AXI address width.
- BURST_LEN, 16: beats per burst, 1..256.
- NUM_BURSTS, 4: bursts per run, 1..16.
- BASE_ADDR, 0: byte address of burst 0; aligned to BURST_LEN*DATA_W/8.
- ACLK  in  1  single clock; all logic on rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle run request; ignored while busy.
- mode  in  2  pattern: 0 incrementing, 1 LFSR, 2 all-ones, 3 all-zeros; sampled with start.
- busy  out  1  high from cycle after accepted start until done.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  valid from done until next accepted start; 1 iff err_count==0.
- err_count  out  16  error events this run, saturating at 0xFFFF.
- m_axi_awaddr / m_axi_araddr  out  ADDR_W  burst k address = BASE_ADDR + k*BURST_LEN*DATA_W/8.
- m_axi_awlen / m_axi_arlen  out  8  constant BURST_LEN-1.
- m_axi_awsize / m_axi_arsize  out  3  constant log2(DATA_W/8).
- m_axi_awburst / m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_awvalid / m_axi_arvalid  out  1  address valid.
- m_axi_awready / m_axi_arready  in  1  address ready.
- m_axi_wdata  out  DATA_W  write data.
- m_axi_wstrb  out  DATA_W/8  all ones.
- m_axi_wlast, m_axi_wvalid  out  1 each  last beat / data valid.
- m_axi_wready  in  1  write ready.
- m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1  write response.
- m_axi_rdata  in  DATA_W; m_axi_rresp  in  2; m_axi_rlast  in  1; m_axi_rvalid  in  1; m_axi_rready  out  1  read data.

## Operation
- FSM: IDLE -> WR_ADDR -> WR_DATA -> WR_RESP. After NUM_BURSTS writes -> RD_ADDR -> RD_DATA. After NUM_BURSTS reads -> FINISH -> IDLE.
- Writes all complete before the first AR. One outstanding burst at a time.
- Pattern uses global beat index g = 0..NUM_BURSTS*BURST_LEN-1. 32-bit lane i of a beat is filled LSB-first.
  - incr: lane = g*(DATA_W/32)+i.
  - LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, seed 0xABCDEF01, one step per lane.
  - ones / zeros: constant.
- The pattern generator restarts (index 0, seed reloaded) on entering WR_ADDR for burst 0 and on entering RD_ADDR for burst 0.
- Error events, each +1 to err_count, saturating:
  - bresp != OKAY;
  - rresp != OKAY on any beat;
  - rdata != expected on any beat;
  - rlast asserted on a beat other than the last, or deasserted on the last beat.
- The read phase always consumes exactly BURST_LEN beats per burst, regardless of rlast.
- err_count and pass clear on accepted start.

## Timing
- Reset values: all valids 0, bready 0, rready 0, busy 0, done 0, pass 0, err_count 0, FSM IDLE. Registered outputs take reset values on the edge where ARESET is sampled high.
- Reset mid-run aborts the run immediately. No done pulse. A later start runs cleanly.
- awvalid/arvalid rise the cycle after entering the address state. Each is held, with stable address, until the ready handshake.
- wvalid is high throughout WR_DATA. Data advances only on wvalid&wready. wlast is high on beat BURST_LEN-1.
- bready is high only in WR_RESP. rready is high only in RD_DATA.
- Compare happens on the cycle of rvalid&rready; err_count updates the next cycle.
- Zero-wait slave: write burst = BURST_LEN+2 cycles, read burst = BURST_LEN+1 cycles, plus 1 cycle FINISH. done asserts in the cycle after the final R handshake's FINISH state.
- start in the same cycle as done is accepted.

## Structure
- Package axi_selftest_pkg holds: FSM state enum, mode enum, RESP_OKAY/EXOKAY/SLVERR, BURST_INCR, LFSR polynomial and seed constants.
- One sub-module, selftest_pattern_gen: restart, advance, mode; DATA_W output. A single instance is shared by the write source and the read comparator.

## Test plan
- DATA_W=32, BURST_LEN=16, NUM_BURSTS=1, mode 0, zero-wait memory slave -> wdata 0x0..0xF; done at cycle 37 after start; pass=1, err_count=0.
- mode 1, NUM_BURSTS=4, random 0-3 cycle backpressure on all ready/valid -> AW/AR addresses 0x00,0x40,0x80,0xC0; first wdata 0xABCDEF01; pass=1.
- Slave flips bit 0 of beat 5, burst 2 on read -> err_count=1, pass=0.
- bresp=SLVERR on burst 0, plus early rlast on beat 3 of burst 1 -> err_count=2.
- ARESET high for 1 cycle during WR_DATA -> next cycle all valids/busy 0. A new start gives pass=1.
- DATA_W=128, mode 0, start pulsed again while busy -> beat 0 = 0x00000003_00000002_00000001_00000000; second start ignored; exactly one done.

Source files
------------

// File: rtl/axi_selftest_pkg.sv
// Shared types and constants for the AXI4 burst self-test master.
package axi_selftest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_ONES  = 2'd2,
    MODE_ZEROS = 2'd3
  } mode_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hABCD_EF01;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/selftest_pattern_gen.sv
// Beat pattern source, shared by the write path and the read comparator.
// Lane i of each beat is filled LSB-first; one LFSR step per 32-bit lane.
module selftest_pattern_gen
  import axi_selftest_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              restart,
  input  logic              advance,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] data
);

  localparam int LANES = DATA_W / 32;

  logic [31:0] idx_q;
  logic [31:0] lfsr_q;
  logic [31:0] lane_lfsr [LANES];
  logic [31:0] lfsr_next;

  always_comb begin
    lane_lfsr[0] = lfsr_q;
    for (int i = 1; i < LANES; i++) lane_lfsr[i] = lfsr_step(lane_lfsr[i-1]);
    lfsr_next = lfsr_step(lane_lfsr[LANES-1]);
  end

  always_comb begin
    data = '0;
    for (int i = 0; i < LANES; i++) begin
      case (mode)
        MODE_INCR: data[32*i +: 32] = idx_q + 32'(i);
        MODE_LFSR: data[32*i +: 32] = lane_lfsr[i];
        MODE_ONES: data[32*i +: 32] = '1;
        default:   data[32*i +: 32] = '0;
      endcase
    end
  end

  // idx_q holds g*LANES, the incrementing value of lane 0.
  always_ff @(posedge ACLK) begin
    if (ARESET || restart) begin
      idx_q  <= '0;
      lfsr_q <= LFSR_SEED;
    end else if (advance) begin
      idx_q  <= idx_q + 32'(LANES);
      lfsr_q <= lfsr_next;
    end
  end

endmodule

// File: rtl/axi4_burst_selftest_master.sv
// AXI4 master that writes NUM_BURSTS INCR bursts of a pattern, reads them back
// and counts response/data/rlast errors in hardware.
//   state      | meaning
//   IDLE       | waiting for start
//   WR_ADDR    | AW held until awready
//   WR_DATA    | BURST_LEN write beats
//   WR_RESP    | waiting for bvalid
//   RD_ADDR    | AR held until arready
//   RD_DATA    | BURST_LEN read beats, each compared
//   FINISH     | latch pass, done pulses next cycle
module axi4_burst_selftest_master
  import axi_selftest_pkg::*;
#(
  parameter int              DATA_W     = 32,
  parameter int              ADDR_W     = 32,
  parameter int              BURST_LEN  = 16,
  parameter int              NUM_BURSTS = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                start,
  input  logic [1:0]          mode,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  localparam int          BURST_BYTES = BURST_LEN * (DATA_W / 8);
  localparam logic [7:0]  AXLEN       = 8'(BURST_LEN - 1);
  localparam logic [2:0]  AXSIZE      = 3'($clog2(DATA_W / 8));
  localparam logic [3:0]  LAST_BURST  = 4'(NUM_BURSTS - 1);

  state_t            state_q, state_d;
  logic [7:0]        beat_q;
  logic [3:0]        burst_q;
  logic [1:0]        mode_q;
  logic              aw_valid_q, ar_valid_q;
  logic              done_q, pass_q;
  logic [15:0]       err_q;
  logic [DATA_W-1:0] pg_data;
  logic [ADDR_W-1:0] burst_addr;

  logic start_ok, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic last_beat, last_burst;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  assign start_ok   = (state_q == ST_IDLE) && start;
  assign aw_hs      = aw_valid_q && m_axi_awready;
  assign w_hs       = (state_q == ST_WR_DATA) && m_axi_wready;
  assign b_hs       = (state_q == ST_WR_RESP) && m_axi_bvalid;
  assign ar_hs      = ar_valid_q && m_axi_arready;
  assign r_hs       = (state_q == ST_RD_DATA) && m_axi_rvalid;
  assign last_beat  = (beat_q == AXLEN);
  assign last_burst = (burst_q == LAST_BURST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_WR_ADDR;
      ST_WR_ADDR: if (aw_hs) state_d = ST_WR_DATA;
      ST_WR_DATA: if (w_hs && last_beat) state_d = ST_WR_RESP;
      ST_WR_RESP: if (b_hs) state_d = last_burst ? ST_RD_ADDR : ST_WR_ADDR;
      ST_RD_ADDR: if (ar_hs) state_d = ST_RD_DATA;
      ST_RD_DATA: if (r_hs && last_beat) state_d = last_burst ? ST_FINISH : ST_RD_ADDR;
      ST_FINISH:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A single read beat can raise up to three separate error events.
  assign err_inc = 2'(b_hs && (m_axi_bresp != RESP_OKAY))
                 + 2'(r_hs && (m_axi_rresp != RESP_OKAY))
                 + 2'(r_hs && (m_axi_rdata != pg_data))
                 + 2'(r_hs && (m_axi_rlast != last_beat));
  assign err_sum = {1'b0, err_q} + 17'(err_inc);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      burst_q    <= '0;
      mode_q     <= '0;
      aw_valid_q <= 1'b0;
      ar_valid_q <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      aw_valid_q <= (state_d == ST_WR_ADDR);
      ar_valid_q <= (state_d == ST_RD_ADDR);
      done_q     <= (state_q == ST_FINISH);
      if (start_ok) begin
        mode_q  <= mode;
        err_q   <= '0;
        pass_q  <= 1'b0;
        burst_q <= '0;
        beat_q  <= '0;
      end else begin
        err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (state_q == ST_FINISH) pass_q <= (err_q == 16'd0);
        if (w_hs || r_hs) beat_q <= last_beat ? 8'd0 : beat_q + 8'd1;
        if (b_hs || (r_hs && last_beat)) burst_q <= last_burst ? 4'd0 : burst_q + 4'd1;
      end
    end
  end

  selftest_pattern_gen #(.DATA_W(DATA_W)) u_pattern (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .restart (start_ok || (b_hs && last_burst)),
    .advance (w_hs || r_hs),
    .mode    (mode_q),
    .data    (pg_data)
  );

  assign burst_addr = BASE_ADDR + ADDR_W'(burst_q) * ADDR_W'(BURST_BYTES);

  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign m_axi_awaddr  = burst_addr;
  assign m_axi_awlen   = AXLEN;
  assign m_axi_awsize  = AXSIZE;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awvalid = aw_valid_q;
  assign m_axi_wdata   = pg_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = (state_q == ST_WR_DATA);
  assign m_axi_wlast   = (state_q == ST_WR_DATA) && last_beat;
  assign m_axi_bready  = (state_q == ST_WR_RESP);
  assign m_axi_araddr  = burst_addr;
  assign m_axi_arlen   = AXLEN;
  assign m_axi_arsize  = AXSIZE;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arvalid = ar_valid_q;
  assign m_axi_rready  = (state_q == ST_RD_DATA);

endmodule
